ppg_window_analyzer: RTL and testbench
======================================

// Module: ppg_window_analyzer
// PURPOSE
//  Downstream consumer of the LED/PGA controller's RED/IR ADC sample stream after setting-find completes.
//  Per measurement window, extracts AC (peak-to-peak) and DC (mid-level) for RED and IR.
//  Detects heartbeats on IR and reports the beat period in IR samples.
//  Feeds the SpO2 ratio and heart-rate stages.
// PARAMETERS
//  WIN_LEN     1024  IR samples per measurement window (>=2)
//  HYST        4     beat-detector hysteresis around the reference DC, ADC codes
//  BEAT_MIN    40    minimum accepted beat period, IR samples; shorter beats are rejected as noise
// PORTS
//  CLK            in   1   system clock, all logic on posedge
//  rst_n          in   1   synchronous active-low reset
//  enable         in   1   high once controller setting-find is complete
//  sample_valid   in   1   one-cycle strobe: sample_data is valid
//  sample_red     in   1   1 = RED sample, 0 = IR sample (meaningful with sample_valid)
//  sample_data    in   8   ADC code
//  red_ac,red_dc  out  8   RED peak-to-peak and mid-level of last window
//  ir_ac,ir_dc    out  8   IR peak-to-peak and mid-level of last window
//  meas_valid     out  1   one-cycle pulse: the four AC/DC outputs were just updated
//  beat_period    out  16  IR samples between the last two accepted beats
//  beat_valid     out  1   one-cycle pulse: beat_period was just updated
// BEHAVIOUR
//  Reset: all outputs 0; max trackers 0, min trackers 255, counters 0, state IDLE.
//  FSM:
//   IDLE  -> FIRST when enable=1.
//   FIRST -> TRACK at the first window close. Windows are measured, but there is no beat reference yet.
//   TRACK: beat detection active.
//   Any state -> IDLE when enable=0: the partial window and all beat state are discarded; outputs are held.
//  Sample acceptance: a sample is accepted only when sample_valid=1 in FIRST or TRACK.
//   Each accepted sample updates that channel's max/min.
//   Each accepted IR sample increments win_cnt.
//  Window close:
//   The accepted IR sample that makes win_cnt = WIN_LEN closes the window, and that sample is included.
//   Next cycle: outputs updated, meas_valid=1, trackers re-armed (max=0, min=255), win_cnt=0.
//   Window-close latency is 1 cycle.
//  Arithmetic:
//   ac = max - min (8 bit).
//   dc = (max + min) >> 1, using a 9-bit sum and truncation.
//   A channel with no samples in the window (max < min) outputs ac=0 and dc=0.
//  Reference: ref_dc = ir_dc of the previous window.
//   lo_th = sat0(ref_dc - HYST); hi_th = sat255(ref_dc + HYST).
//  Beat detection (TRACK, accepted IR samples only):
//   IR < lo_th sets armed.
//   Beat: armed and IR >= hi_th. On a beat, armed is cleared.
//   per_cnt counts accepted IR samples since the last beat and saturates at 16'hFFFF.
//   On a beat, let p = sat(per_cnt + 1):
//    - First beat since entering TRACK: per_cnt <= 0; no output.
//    - Otherwise, if p >= BEAT_MIN: beat_period <= p, beat_valid=1 next cycle, per_cnt <= 0.
//    - Otherwise (p < BEAT_MIN): the beat is ignored and per_cnt keeps counting.
//  Simultaneous events:
//   A beat on the window-closing sample uses the OLD ref_dc; the new ref_dc applies from the next sample.
//   meas_valid and beat_valid may pulse in the same cycle.
//   A RED sample never closes a window and never affects beat detection.
//  sample_valid with enable=0 is ignored. Reset mid-window behaves exactly as power-on reset.
// CONFIGURATION
//  Macro PPG_AVG_EN.
//  Defined: red_ac/red_dc/ir_ac/ir_dc are the mean of the last 4 window results.
//   - Each is a 10-bit sum >> 2, using a 4-deep history per output.
//   - The history is cleared on reset and on entry to IDLE.
//   - Until 4 windows exist, the missing entries count as 0.
//   - ref_dc always uses the raw (un-averaged) ir_dc.
//  Undefined: raw single-window results, with no history registers.
// STRUCTURE
//  Package ppg_pkg:
//   - state enum IDLE/FIRST/TRACK
//   - ADC_W=8, PER_W=16
//   - sat_add/sat_sub helper functions
//  Sub-module ppg_minmax_tracker:
//   - per-channel max/min with a re-arm input and an ac/dc/empty output
//   - instantiated twice (RED, IR)
// TESTING
//  1. WIN_LEN=8, alternating RED/IR; IR ramp 100..107, RED fixed 50.
//     Expect meas_valid once, ir_ac=7, ir_dc=103, red_ac=0, red_dc=50.
//  2. IR only, no RED samples in the window.
//     Expect red_ac=0, red_dc=0, and IR results correct.
//  3. TRACK with ref_dc=128, HYST=4; IR square wave 100/160 with a period of 50 IR samples.
//     Expect the first beat silent, then beat_valid with beat_period=50 every 50 IR samples.
//  4. Glitch: IR dips to 100 and returns to 160 within 10 samples (< BEAT_MIN=40).
//     Expect no beat_valid; the next true beat reports the full accumulated period.
//  5. Deassert enable mid-window at win_cnt=5, then reassert.
//     Expect no meas_valid for the partial window, FIRST re-entered, and the next meas_valid after a full WIN_LEN.
//  6. PPG_AVG_EN defined; 4 windows with ir_ac = 8, 16, 24, 32.
//     Expect ir_ac outputs 2, 6, 12, 20; then rst_n=0 for 1 cycle forces all outputs to 0.

Source files
------------

// File: rtl/ppg_pkg.sv
// Shared types, widths and saturating helpers for the PPG window analyzer.
package ppg_pkg;

  localparam int ADC_W = 8;
  localparam int PER_W = 16;

  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_t;

  function automatic logic [ADC_W-1:0] sat_add(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    logic [ADC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ADC_W] ? {ADC_W{1'b1}} : s[ADC_W-1:0];
  endfunction

  function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/ppg_minmax_tracker.sv
// Per-channel max/min tracker; ac/dc/empty outputs already include the sample
// being accepted this cycle, so a window can close on that sample without extra delay.
module ppg_minmax_tracker
  import ppg_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_upd,
  input  logic             i_rearm,
  input  logic [ADC_W-1:0] i_data,
  output logic [ADC_W-1:0] o_ac,
  output logic [ADC_W-1:0] o_dc,
  output logic             o_empty
);

  logic [ADC_W-1:0] r_max, r_min;
  logic [ADC_W-1:0] w_max, w_min;
  logic [ADC_W:0]   w_sum;

  always_comb begin
    w_max = r_max;
    w_min = r_min;
    if (i_upd && (i_data > r_max)) w_max = i_data;
    if (i_upd && (i_data < r_min)) w_min = i_data;
    o_empty = (w_max < w_min);
    w_sum   = {1'b0, w_max} + {1'b0, w_min};
    o_ac    = o_empty ? '0 : (w_max - w_min);
    o_dc    = o_empty ? '0 : w_sum[ADC_W:1];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_rearm) begin
      r_max <= '0;
      r_min <= '1;
    end else begin
      r_max <= w_max;
      r_min <= w_min;
    end
  end

endmodule

// File: rtl/ppg_window_analyzer.sv
// Per-window RED/IR AC/DC extraction and IR beat-period detection; results 1 cycle after the closing sample.
// PPG_AVG_EN: AC/DC outputs become the mean of the last 4 window results.
module ppg_window_analyzer
  import ppg_pkg::*;
#(
  parameter int WIN_LEN  = 1024,
  parameter int HYST     = 4,
  parameter int BEAT_MIN = 40
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_sample_valid,
  input  logic             i_sample_red,
  input  logic [ADC_W-1:0] i_sample_data,
  output logic [ADC_W-1:0] o_red_ac,
  output logic [ADC_W-1:0] o_red_dc,
  output logic [ADC_W-1:0] o_ir_ac,
  output logic [ADC_W-1:0] o_ir_dc,
  output logic             o_meas_valid,
  output logic [PER_W-1:0] o_beat_period,
  output logic             o_beat_valid
);

  localparam int               CNT_W      = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WIN_LEN - 1);
  localparam logic [ADC_W-1:0] HYST_C     = ADC_W'(HYST);
  localparam logic [PER_W-1:0] BEAT_MIN_C = PER_W'(BEAT_MIN);

  state_t           r_state;
  logic [CNT_W-1:0] r_win_cnt;
  logic [ADC_W-1:0] r_ref_dc;
  logic             r_armed;
  logic             r_first_beat;
  logic [PER_W-1:0] r_per_cnt;

  logic             w_acc, w_red_acc, w_ir_acc, w_close, w_rearm, w_track_ir, w_beat;
  logic [ADC_W-1:0] w_lo_th, w_hi_th;
  logic [PER_W-1:0] w_p;
  logic [ADC_W-1:0] w_red_ac, w_red_dc, w_ir_ac, w_ir_dc;
  logic             w_red_empty, w_ir_empty;

  assign w_acc      = i_sample_valid && i_enable && (r_state != IDLE);
  assign w_red_acc  = w_acc && i_sample_red;
  assign w_ir_acc   = w_acc && !i_sample_red;
  assign w_close    = w_ir_acc && (r_win_cnt == LAST_CNT);
  assign w_rearm    = !i_enable || w_close;
  assign w_lo_th    = sat_sub(r_ref_dc, HYST_C);
  assign w_hi_th    = sat_add(r_ref_dc, HYST_C);
  assign w_track_ir = w_ir_acc && (r_state == TRACK);
  assign w_beat     = w_track_ir && r_armed && (i_sample_data >= w_hi_th);
  assign w_p        = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + 1'b1;

  ppg_minmax_tracker u_red (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_upd  (w_red_acc),
    .i_rearm(w_rearm),
    .i_data (i_sample_data),
    .o_ac   (w_red_ac),
    .o_dc   (w_red_dc),
    .o_empty(w_red_empty)
  );

  ppg_minmax_tracker u_ir (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_upd  (w_ir_acc),
    .i_rearm(w_rearm),
    .i_data (i_sample_data),
    .o_ac   (w_ir_ac),
    .o_dc   (w_ir_dc),
    .o_empty(w_ir_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_win_cnt     <= '0;
      r_ref_dc      <= '0;
      r_armed       <= 1'b0;
      r_first_beat  <= 1'b1;
      r_per_cnt     <= '0;
      o_meas_valid  <= 1'b0;
      o_beat_period <= '0;
      o_beat_valid  <= 1'b0;
    end else begin
      o_meas_valid <= 1'b0;
      o_beat_valid <= 1'b0;
      if (!i_enable) begin
        r_state      <= IDLE;
        r_win_cnt    <= '0;
        r_armed      <= 1'b0;
        r_first_beat <= 1'b1;
        r_per_cnt    <= '0;
      end else if (r_state == IDLE) begin
        r_state <= FIRST;
      end else begin
        if (w_ir_acc) r_win_cnt <= w_close ? '0 : r_win_cnt + 1'b1;
        if (w_close) begin
          o_meas_valid <= 1'b1;
          r_ref_dc     <= w_ir_dc;
          if (r_state == FIRST) begin
            r_state      <= TRACK;
            r_armed      <= 1'b0;
            r_first_beat <= 1'b1;
            r_per_cnt    <= '0;
          end
        end
        // Beat on the closing sample still compares against the old reference
        if (w_track_ir) begin
          if (w_beat) begin
            r_armed <= 1'b0;
            if (r_first_beat) begin
              r_first_beat <= 1'b0;
              r_per_cnt    <= '0;
            end else if (w_p >= BEAT_MIN_C) begin
              o_beat_period <= w_p;
              o_beat_valid  <= 1'b1;
              r_per_cnt     <= '0;
            end else begin
              r_per_cnt <= w_p;
            end
          end else begin
            if (i_sample_data < w_lo_th) r_armed <= 1'b1;
            r_per_cnt <= w_p;
          end
        end
      end
    end
  end

`ifdef PPG_AVG_EN
  logic [ADC_W-1:0] w_new [4];
  logic [ADC_W+1:0] w_sum [4];
  logic [ADC_W-1:0] r_hist [4][3];
  logic [ADC_W-1:0] r_avg [4];

  always_comb begin
    w_new[0] = w_red_ac;
    w_new[1] = w_red_dc;
    w_new[2] = w_ir_ac;
    w_new[3] = w_ir_dc;
    for (int k = 0; k < 4; k++) begin
      w_sum[k] = {2'b00, w_new[k]} + {2'b00, r_hist[k][0]} +
                 {2'b00, r_hist[k][1]} + {2'b00, r_hist[k][2]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_avg[k] <= '0;
        for (int j = 0; j < 3; j++) r_hist[k][j] <= '0;
      end
    end else if (!i_enable) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 3; j++) r_hist[k][j] <= '0;
      end
    end else if (w_close) begin
      for (int k = 0; k < 4; k++) begin
        r_avg[k]     <= w_sum[k][ADC_W+1:2];
        r_hist[k][0] <= w_new[k];
        r_hist[k][1] <= r_hist[k][0];
        r_hist[k][2] <= r_hist[k][1];
      end
    end
  end

  assign o_red_ac = r_avg[0];
  assign o_red_dc = r_avg[1];
  assign o_ir_ac  = r_avg[2];
  assign o_ir_dc  = r_avg[3];
`else
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_red_ac <= '0;
      o_red_dc <= '0;
      o_ir_ac  <= '0;
      o_ir_dc  <= '0;
    end else if (w_close) begin
      o_red_ac <= w_red_ac;
      o_red_dc <= w_red_dc;
      o_ir_ac  <= w_ir_ac;
      o_ir_dc  <= w_ir_dc;
    end
  end
`endif

  // Emptiness is already folded into the ac/dc values; flags kept for visibility
  logic w_unused;
  assign w_unused = w_red_empty ^ w_ir_empty;

endmodule

// File: tb/tb_ppg_window_analyzer.sv
// Scoreboard bench for ppg_window_analyzer: a window/beat reference model feeds expected-event queues.
module tb_ppg_window_analyzer;

  localparam int WL = 32;
  localparam int HY = 4;
  localparam int BM = 40;
`ifdef PPG_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0, i_enable = 1'b0, i_sample_valid = 1'b0, i_sample_red = 1'b0;
  logic [7:0]  i_sample_data = '0;
  logic [7:0]  o_red_ac, o_red_dc, o_ir_ac, o_ir_dc;
  logic        o_meas_valid, o_beat_valid;
  logic [15:0] o_beat_period;

  always #5 clk = ~clk;

  ppg_window_analyzer #(.WIN_LEN(WL), .HYST(HY), .BEAT_MIN(BM)) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_enable      (i_enable),
    .i_sample_valid(i_sample_valid),
    .i_sample_red  (i_sample_red),
    .i_sample_data (i_sample_data),
    .o_red_ac      (o_red_ac),
    .o_red_dc      (o_red_dc),
    .o_ir_ac       (o_ir_ac),
    .o_ir_dc       (o_ir_dc),
    .o_meas_valid  (o_meas_valid),
    .o_beat_period (o_beat_period),
    .o_beat_valid  (o_beat_valid)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rst_cyc = -1;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; longint v;} ev_t;
  ev_t mq[$];
  ev_t bq[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int mode = 0;                // 0 idle, 1 first window, 2 tracking
  int irq[$];
  int redq[$];
  int ref_dc = 0;
  bit armed, seen;
  int idx, last;
  int hist[4][3];

  task automatic beat_clear();
    armed = 0; seen = 0; idx = 0; last = 0;
  endtask

  task automatic hist_clear();
    for (int k = 0; k < 4; k++) for (int j = 0; j < 3; j++) hist[k][j] = 0;
  endtask

  task automatic acdc(input int q[$], output int ac, output int dc);
    int mx, mn;
    if (q.size() == 0) begin ac = 0; dc = 0; return; end
    mx = q[0]; mn = q[0];
    foreach (q[i]) begin
      if (q[i] > mx) mx = q[i];
      if (q[i] < mn) mn = q[i];
    end
    ac = mx - mn;
    dc = (mx + mn) / 2;
  endtask

  task automatic close_window();
    int nv[4];
    int ov[4];
    ev_t e;
    acdc(redq, nv[0], nv[1]);
    acdc(irq, nv[2], nv[3]);
    for (int k = 0; k < 4; k++) begin
      if (AVG) begin
        ov[k] = (nv[k] + hist[k][0] + hist[k][1] + hist[k][2]) / 4;
        hist[k][2] = hist[k][1]; hist[k][1] = hist[k][0]; hist[k][0] = nv[k];
      end else begin
        ov[k] = nv[k];
      end
    end
    e.cyc = cyc + 1;
    e.v = (longint'(ov[0]) << 24) | (longint'(ov[1]) << 16) | (longint'(ov[2]) << 8) | longint'(ov[3]);
    mq.push_back(e);
    ref_dc = nv[3];
    irq.delete();
    redq.delete();
    if (mode == 1) begin mode = 2; beat_clear(); end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit vld, input bit red, input int d);
    int lo, hi, p;
    ev_t e;
    if (!rst) begin
      mode = 0; irq.delete(); redq.delete(); ref_dc = 0; beat_clear(); hist_clear();
      return;
    end
    if (!en) begin
      if (mode != 0) begin irq.delete(); redq.delete(); beat_clear(); hist_clear(); end
      mode = 0;
      return;
    end
    if (mode == 0) begin mode = 1; return; end
    if (!vld) return;
    if (red) begin redq.push_back(d); return; end
    if (mode == 2) begin
      lo = (ref_dc - HY < 0) ? 0 : ref_dc - HY;
      hi = (ref_dc + HY > 255) ? 255 : ref_dc + HY;
      idx++;
      if (armed && d >= hi) begin
        armed = 0;
        if (!seen) begin
          seen = 1; last = idx;
        end else begin
          p = idx - last;
          if (p > 65535) p = 65535;
          if (p >= BM) begin
            e.cyc = cyc + 1; e.v = p; bq.push_back(e); last = idx;
          end
        end
      end else if (d < lo) begin
        armed = 1;
      end
    end
    irq.push_back(d);
    if (irq.size() == WL) close_window();
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input bit rst, input bit en, input bit vld, input bit red, input logic [7:0] d);
    @(posedge clk);
    #1;
    i_rst_n = rst; i_enable = en; i_sample_valid = vld; i_sample_red = red; i_sample_data = d;
    if (!rst) rst_cyc = cyc + 1;
    model_step(rst, en, vld, red, int'(d));
  endtask

  task automatic ir(input int d);
    drive(1, 1, 1, 0, 8'(d));
  endtask

  task automatic red(input int d);
    drive(1, 1, 1, 1, 8'(d));
  endtask

  function automatic int square(input int n);
    return ((n % 50) < 25) ? 100 : 160;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    longint hold_v;
    longint hold_bp;
    longint act;
    ev_t e;
    hold_v = 0; hold_bp = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (cyc == rst_cyc) begin hold_v = 0; hold_bp = 0; end
        act = {o_red_ac, o_red_dc, o_ir_ac, o_ir_dc};
        if (o_meas_valid) begin
          if (mq.size() == 0) chk("meas_unexpected", 1, 0);
          else begin
            e = mq.pop_front();
            chk("meas_cycle", cyc, e.cyc);
            chk("meas_values", act, e.v);
            hold_v = e.v;
          end
        end else begin
          if (mq.size() > 0 && mq[0].cyc <= cyc) begin
            e = mq.pop_front();
            chk("meas_missing", 0, 1);
            hold_v = e.v;
          end
          chk("meas_hold", act, hold_v);
        end
        if (o_beat_valid) begin
          if (bq.size() == 0) chk("beat_unexpected", 1, 0);
          else begin
            e = bq.pop_front();
            chk("beat_cycle", cyc, e.cyc);
            chk("beat_period", o_beat_period, e.v);
            hold_bp = e.v;
          end
        end else begin
          if (bq.size() > 0 && bq[0].cyc <= cyc) begin
            e = bq.pop_front();
            chk("beat_missing", 0, 1);
            hold_bp = e.v;
          end
          chk("beat_hold", o_beat_period, hold_bp);
        end
      end
    end
  end

  initial begin
    int r, v, per, half, ph, off_left;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 8'd0);
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_meas_outs", {o_red_ac, o_red_dc, o_ir_ac, o_ir_dc}, 0);
    chk("reset_beat_out", o_beat_period, 0);
    chk("reset_valids", {o_meas_valid, o_beat_valid}, 0);

    drive(1, 1, 0, 0, 8'd0);
    // interleaved RED/IR, IR ramp
    for (int i = 0; i < WL; i++) begin red(50); ir(100 + i); end
    drive(1, 1, 0, 0, 8'd0);
    // IR only, with idle gaps
    for (int i = 0; i < WL; i++) begin
      ir(120 + (i % 5) * 3);
      if (i % 7 == 0) drive(1, 1, 0, 0, 8'd0);
    end
    // square wave, period 50 IR samples
    for (int n = 0; n < 300; n++) ir(square(n));
    // short glitch after a beat, then clean period
    for (int n = 0; n < 150; n++) begin
      v = square(n);
      if (n >= 30 && n <= 32) v = 100;
      ir(v);
    end
    // enable drop mid-window
    while (irq.size() != 5) ir(110 + irq.size());
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 8'd200);
    drive(1, 1, 0, 0, 8'd0);
    for (int i = 0; i < WL; i++) begin ir(90 + (i % 3)); if (i % 4 == 0) red(70 + i); end
    // four windows with ir_ac 8,16,24,32
    for (int w = 1; w <= 4; w++)
      for (int i = 0; i < WL; i++) ir((i % 2) ? 100 + 8 * w : 100);
    drive(1, 1, 0, 0, 8'd0);
    drive(1, 1, 0, 0, 8'd0);
    drive(0, 1, 0, 0, 8'd0);
    drive(1, 1, 0, 0, 8'd0);
    @(negedge clk);
    chk("midrun_reset_outs", {o_red_ac, o_red_dc, o_ir_ac, o_ir_dc, o_beat_period}, 0);

    // randomized traffic
    per = 50; half = 25; ph = 0; off_left = 0;
    for (int n = 0; n < 5000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) drive(0, 1, 0, 0, 8'd0);
      else if (off_left > 0) begin
        off_left--;
        drive(1, 0, 1'($urandom_range(0, 1)), 0, 8'($urandom));
      end else if (r < 8) begin
        off_left = int'($urandom_range(1, 4));
        drive(1, 0, 0, 0, 8'd0);
      end else begin
        if (r < 14) begin per = int'($urandom_range(30, 90)); half = per / 2; end
        if ($urandom_range(0, 9) < 3) drive(1, 1, 0, 0, 8'd0);
        else if ($urandom_range(0, 9) < 3) red(int'($urandom_range(20, 240)));
        else begin
          ph = (ph + 1) % per;
          v = (ph < half) ? 60 + int'($urandom_range(0, 6)) : 180 + int'($urandom_range(0, 6));
          if ($urandom_range(0, 99) == 0) v = int'($urandom_range(0, 255));
          ir(v);
        end
      end
    end
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 8'd0);
    @(negedge clk);
    chk("meas_queue_drained", mq.size(), 0);
    chk("beat_queue_drained", bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
